// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// rom_arbiter : shares one ROM controller between instruction and data buses
// Revision    : 1.0
// ============================================================================

`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module rom_arbiter #(
    parameter int BYTE_ADDR_WIDTH = 12,
    parameter int ACC_W           = $clog2(`BUS_ACC_CNT)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_req,
    input  logic [BYTE_ADDR_WIDTH-1:0] i_addr,
    input  logic                       i_wr_b,
    input  logic [ACC_W-1:0]           i_acc,
    input  logic [31:0]                i_wdata,
    output logic                       i_resp,
    output logic [31:0]                i_rdata,
    output logic                       i_fault,
    input  logic                       d_req,
    input  logic [BYTE_ADDR_WIDTH-1:0] d_addr,
    input  logic                       d_wr_b,
    input  logic [ACC_W-1:0]           d_acc,
    input  logic [31:0]                d_wdata,
    output logic                       d_resp,
    output logic [31:0]                d_rdata,
    output logic                       d_fault,
    output logic                       m_req,
    output logic [BYTE_ADDR_WIDTH-1:0] m_addr,
    output logic                       m_wr_b,
    output logic [ACC_W-1:0]           m_acc,
    output logic [31:0]                m_wdata,
    input  logic                       m_resp,
    input  logic [31:0]                m_rdata,
    input  logic                       m_fault,
    output logic                       proto_err
);

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef struct packed {
        logic [BYTE_ADDR_WIDTH-1:0] addr;
        logic                       wr_b;
        logic [ACC_W-1:0]           acc;
        logic [31:0]                wdata;
    } req_t;

    logic busy_i_q, busy_i_d;
    logic busy_d_q, busy_d_d;
    logic pend_vld_q, pend_vld_d;
    logic pend_port_q, pend_port_d;
    req_t pend_q, pend_d;
    logic rr_q, rr_d;
    logic iss_vld_q, iss_vld_d;
    logic iss_port_q, iss_port_d;
    logic iss_fault_q, iss_fault_d;
    logic proto_err_q, proto_err_d;
    req_t last_q, last_d;

    req_t w_i_fields, w_d_fields, w_sel, w_mux;
    logic w_issue, w_sel_port, w_resp;
    logic w_i_acc, w_d_acc, w_i_viol, w_d_viol;

    assign w_i_fields = {i_addr, i_wr_b, i_acc, i_wdata};
    assign w_d_fields = {d_addr, d_wr_b, d_acc, d_wdata};

    assign w_resp  = m_resp & iss_vld_q;
    assign i_resp  = w_resp & (iss_port_q == PORT_I);
    assign d_resp  = w_resp & (iss_port_q == PORT_D);
    assign i_fault = i_resp & iss_fault_q;
    assign d_fault = d_resp & iss_fault_q;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // A port's resp cycle frees it, so a back-to-back request is legal there.
    assign w_i_acc  = i_req & (~busy_i_q | i_resp);
    assign w_d_acc  = d_req & (~busy_d_q | d_resp);
    assign w_i_viol = i_req & busy_i_q & ~i_resp;
    assign w_d_viol = d_req & busy_d_q & ~d_resp;

    always_comb begin
        w_issue     = 1'b0;
        w_sel_port  = PORT_I;
        w_sel       = pend_q;
        pend_vld_d  = 1'b0;
        pend_port_d = pend_port_q;
        pend_d      = pend_q;
        rr_d        = rr_q;

        if (pend_vld_q) begin
            w_issue    = 1'b1;
            w_sel_port = pend_port_q;
            w_sel      = pend_q;
            if (w_i_acc) begin
                pend_vld_d  = 1'b1;
                pend_port_d = PORT_I;
                pend_d      = w_i_fields;
            end else if (w_d_acc) begin
                pend_vld_d  = 1'b1;
                pend_port_d = PORT_D;
                pend_d      = w_d_fields;
            end
        end else if (w_i_acc && w_d_acc) begin
            w_issue    = 1'b1;
            pend_vld_d = 1'b1;
            rr_d       = ~rr_q;
            if (rr_q == PORT_I) begin
                w_sel_port  = PORT_I;
                w_sel       = w_i_fields;
                pend_port_d = PORT_D;
                pend_d      = w_d_fields;
            end else begin
                w_sel_port  = PORT_D;
                w_sel       = w_d_fields;
                pend_port_d = PORT_I;
                pend_d      = w_i_fields;
            end
        end else if (w_i_acc) begin
            w_issue    = 1'b1;
            w_sel_port = PORT_I;
            w_sel      = w_i_fields;
        end else if (w_d_acc) begin
            w_issue    = 1'b1;
            w_sel_port = PORT_D;
            w_sel      = w_d_fields;
        end
    end

    // Fields hold their last issued values whenever nothing is issued.
    assign w_mux   = w_issue ? w_sel : last_q;
    assign m_req   = w_issue & rstn;
    assign m_addr  = w_mux.addr;
    assign m_wr_b  = w_mux.wr_b;
    assign m_acc   = w_mux.acc;
    assign m_wdata = w_mux.wdata;

    always_comb begin
        busy_i_d    = (busy_i_q & ~i_resp) | w_i_acc;
        busy_d_d    = (busy_d_q & ~d_resp) | w_d_acc;
        proto_err_d = proto_err_q | w_i_viol | w_d_viol;
        iss_vld_d   = m_req;
        iss_port_d  = w_sel_port;
        iss_fault_d = m_fault;
        last_d      = w_mux;
    end

    assign proto_err = proto_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_i_q    <= 1'b0;
            busy_d_q    <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_port_q <= PORT_I;
            pend_q      <= '0;
            rr_q        <= PORT_I;
            iss_vld_q   <= 1'b0;
            iss_port_q  <= PORT_I;
            iss_fault_q <= 1'b0;
            proto_err_q <= 1'b0;
            last_q      <= '0;
        end else begin
            busy_i_q    <= busy_i_d;
            busy_d_q    <= busy_d_d;
            pend_vld_q  <= pend_vld_d;
            pend_port_q <= pend_port_d;
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            iss_vld_q   <= iss_vld_d;
            iss_port_q  <= iss_port_d;
            iss_fault_q <= iss_fault_d;
            proto_err_q <= proto_err_d;
            last_q      <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rom_arbiter : directed vector bench for rom_arbiter
// Revision       : 1.0
// ============================================================================

module tb_rom_arbiter;

    localparam int AW = 12;
    localparam int AC = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_req, i_wr_b, d_req, d_wr_b;
    logic [AW-1:0] i_addr, d_addr;
    logic [AC-1:0] i_acc, d_acc;
    logic [31:0]   i_wdata, d_wdata;
    logic          i_resp, i_fault, d_resp, d_fault;
    logic [31:0]   i_rdata, d_rdata;
    logic          m_req, m_wr_b, m_resp, m_fault;
    logic [AW-1:0] m_addr;
    logic [AC-1:0] m_acc;
    logic [31:0]   m_wdata, m_rdata;
    logic          proto_err;

    // downstream model: 1-cycle response, data echoes the issued address
    logic       mresp_q = 1'b0;
    logic [31:0] rdata_q = 32'h0;
    logic [1:0] mf;
    always @(posedge clk) begin
        mresp_q <= m_req;
        if (m_req) rdata_q <= {20'h0, m_addr};
    end
    assign m_resp  = (mf == 2'd1) ? 1'b0 : (mf == 2'd2) ? 1'b1 : mresp_q;
    assign m_rdata = rdata_q;
    assign m_fault = m_req & m_wr_b;

    always #5 clk = ~clk;

    rom_arbiter #(.BYTE_ADDR_WIDTH(AW), .ACC_W(AC)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_wr_b(i_wr_b), .i_acc(i_acc), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata), .i_fault(i_fault),
        .d_req(d_req), .d_addr(d_addr), .d_wr_b(d_wr_b), .d_acc(d_acc), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata), .d_fault(d_fault),
        .m_req(m_req), .m_addr(m_addr), .m_wr_b(m_wr_b), .m_acc(m_acc), .m_wdata(m_wdata),
        .m_resp(m_resp), .m_rdata(m_rdata), .m_fault(m_fault),
        .proto_err(proto_err)
    );

    typedef struct {
        logic          ir; logic [AW-1:0] ia; logic iw;
        logic          dr; logic [AW-1:0] da; logic dw;
        logic [1:0]    mf;
        logic          em;  logic [AW-1:0] ema;
        logic          eir; logic [AW-1:0] eia; logic eif;
        logic          edr; logic [AW-1:0] eda; logic edf;
        logic          ep;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 0;
    vec_t vq[$];

    function automatic vec_t mk(logic ir, logic [AW-1:0] ia, logic iw,
                                logic dr, logic [AW-1:0] da, logic dw, logic [1:0] f,
                                logic em, logic [AW-1:0] ema,
                                logic eir, logic [AW-1:0] eia, logic eif,
                                logic edr, logic [AW-1:0] eda, logic edf, logic ep);
        vec_t v;
        v.ir = ir; v.ia = ia; v.iw = iw; v.dr = dr; v.da = da; v.dw = dw; v.mf = f;
        v.em = em; v.ema = ema; v.eir = eir; v.eia = eia; v.eif = eif;
        v.edr = edr; v.eda = eda; v.edf = edf; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; i_wr_b = 0; i_acc = '0; i_wdata = 32'h1111_0000;
        d_req = 0; d_addr = '0; d_wr_b = 0; d_acc = '0; d_wdata = 32'h2222_0000;
        mf = 2'd0;
    endtask

    // Called just after a rising edge; drives, samples at the falling edge, then advances.
    task automatic apply(input vec_t v);
        i_req = v.ir; i_addr = v.ia; i_wr_b = v.iw;
        d_req = v.dr; d_addr = v.da; d_wr_b = v.dw;
        mf = v.mf;
        @(negedge clk);
        chk("m_req", {31'h0, m_req}, {31'h0, v.em});
        if (v.em) chk("m_addr", {20'h0, m_addr}, {20'h0, v.ema});
        chk("i_resp", {31'h0, i_resp}, {31'h0, v.eir});
        if (v.eir) chk("i_rdata", i_rdata, {20'h0, v.eia});
        chk("i_fault", {31'h0, i_fault}, {31'h0, v.eif});
        chk("d_resp", {31'h0, d_resp}, {31'h0, v.edr});
        if (v.edr) chk("d_rdata", d_rdata, {20'h0, v.eda});
        chk("d_fault", {31'h0, d_fault}, {31'h0, v.edf});
        chk("proto_err", {31'h0, proto_err}, {31'h0, v.ep});
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic run_queue();
        foreach (vq[k]) apply(vq[k]);
        vq.delete();
    endtask

    initial begin
        idle_inputs();
        rstn = 1'b0;
        i_req = 1'b1;
        @(negedge clk);
        chk("rst_m_req", {31'h0, m_req}, 32'h0);
        chk("rst_i_resp", {31'h0, i_resp}, 32'h0);
        chk("rst_d_resp", {31'h0, d_resp}, 32'h0);
        chk("rst_proto", {31'h0, proto_err}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle_inputs();

        //          ir ia      iw dr da      dw mf   em ema      eir eia     eif edr eda     edf ep
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        // solo read
        vq.push_back(mk(1, 12'h104, 0, 0, 12'h000, 0, 0, 1, 12'h104, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h104, 0, 0, 12'h000, 0, 0));
        // simultaneous pair, i wins then d wins
        vq.push_back(mk(1, 12'h010, 0, 1, 12'h020, 0, 0, 1, 12'h010, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 12'h020, 1, 12'h010, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1, 12'h020, 0, 0));
        vq.push_back(mk(1, 12'h010, 0, 1, 12'h020, 0, 0, 1, 12'h020, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 12'h010, 0, 12'h000, 0, 1, 12'h020, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h010, 0, 0, 12'h000, 0, 0));
        // pending beats fresh; i re-requests in its resp cycle
        vq.push_back(mk(1, 12'h040, 0, 1, 12'h050, 0, 0, 1, 12'h040, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(1, 12'h030, 0, 0, 12'h000, 0, 0, 1, 12'h050, 1, 12'h040, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 12'h030, 0, 12'h000, 0, 1, 12'h050, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h030, 0, 0, 12'h000, 0, 0));
        // write faults
        vq.push_back(mk(0, 12'h000, 0, 1, 12'h060, 1, 0, 1, 12'h060, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1, 12'h060, 1, 0));
        // back-to-back on d port
        vq.push_back(mk(0, 12'h000, 0, 1, 12'h070, 0, 0, 1, 12'h070, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 1, 12'h074, 0, 0, 1, 12'h074, 0, 12'h000, 0, 1, 12'h070, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1, 12'h074, 0, 0));
        // unsolicited m_resp ignored
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 2, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        // protocol violation on i port
        vq.push_back(mk(1, 12'h080, 0, 0, 12'h000, 0, 0, 1, 12'h080, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(1, 12'h084, 0, 0, 12'h000, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0, 1));
        vq.push_back(mk(0, 12'h000, 0, 1, 12'h090, 0, 0, 1, 12'h090, 0, 12'h000, 0, 0, 12'h000, 0, 1));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1, 12'h090, 0, 1));
        run_queue();

        // reset clears proto_err asynchronously and blocks m_req
        rstn = 1'b0;
        i_req = 1'b1;
        @(negedge clk);
        chk("rst2_proto", {31'h0, proto_err}, 32'h0);
        chk("rst2_m_req", {31'h0, m_req}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle_inputs();

        // both request, then reset mid-operation
        vq.push_back(mk(1, 12'h0B0, 0, 1, 12'h0C0, 0, 0, 1, 12'h0B0, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        run_queue();
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_i_resp", {31'h0, i_resp}, 32'h0);
        chk("midrst_d_resp", {31'h0, d_resp}, 32'h0);
        chk("midrst_m_req", {31'h0, m_req}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        // stray response, discarded pending, pointer back at i port
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 2, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(1, 12'h0D0, 0, 1, 12'h0E0, 0, 0, 1, 12'h0D0, 0, 12'h000, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 1, 12'h0E0, 1, 12'h0D0, 0, 0, 12'h000, 0, 0));
        vq.push_back(mk(0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1, 12'h0E0, 0, 0));
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares a single `rom_controller` between the instruction-fetch bus and the data bus. It accepts one-cycle request pulses from each requester and issues at most one request per cycle downstream. It holds at most one losing request in a pending slot and routes each downstream response back to the port that owns it. Worst-case request-to-response latency is 2 cycles; uncontended latency matches a direct ROM connection.

## Interface
- `BYTE_ADDR_WIDTH`, default 12: byte address width. Must match the downstream ROM.
- `ACC_W`, default `$clog2(`BUS_ACC_CNT)`: width of the `acc` access-size field.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset; one clock, reset is asynchronous and active-low
- `i_req`  in  1  instruction-port request pulse
- `i_addr`, `i_wr_b`, `i_acc`, `i_wdata`  in  BYTE_ADDR_WIDTH/1/ACC_W/32  request fields; valid only while `i_req`=1
- `i_resp`  out  1  instruction-port response pulse
- `i_rdata`  out  32  read data; valid only while `i_resp`=1
- `i_fault`  out  1  fault for the completing access; valid only while `i_resp`=1
- `d_req`, `d_addr`, `d_wr_b`, `d_acc`, `d_wdata`, `d_resp`, `d_rdata`, `d_fault`: data port, same definitions as the `i_*` ports
- `m_req`, `m_addr`, `m_wr_b`, `m_acc`, `m_wdata`  out  downstream request to the ROM controller
- `m_resp`  in  1  downstream response; arrives 1 cycle after `m_req`
- `m_rdata`  in  32  downstream read data
- `m_fault`  in  1  downstream fault; combinational with `m_req`
- `proto_err`  out  1  sticky protocol-violation flag

## Operation
- **Port rule:** each port has at most one outstanding access. A port may assert a new `req` in the same cycle its `resp` is high.
- **Per-port busy flag:** set when a request is accepted; cleared in the port's `resp` cycle.
- **Protocol violation:** a `req` on a busy port outside its `resp` cycle is dropped and sets `proto_err`. `proto_err` is cleared only by reset.
- **Pending slot:** one entry holding {port, addr, wr_b, acc, wdata}. The design guarantees at most one pending entry at a time.
- **Issue priority each cycle:**
  1. A valid pending entry issues first. Any accepted fresh request in that cycle goes into the pending slot.
  2. Otherwise, if both ports have a fresh request, the round-robin pointer selects the winner. The loser goes into the pending slot.
  3. Otherwise, a sole fresh request issues directly.
- **Round-robin pointer:** 1 bit, points at the preferred port. It updates to the other port only after a both-fresh arbitration. It resets to the i-port.
- **Downstream drive:** `m_req` and the `m_*` fields are driven combinationally from the selected source. Nothing issued means `m_req`=0 and the fields hold their last values.
- **Issue tracking:** on issue, register `iss_vld`=1, `iss_port`, and `iss_fault`=`m_fault`.
- **Response routing:** the next cycle, `m_resp & iss_vld` produces `resp` on `iss_port` with `fault`=`iss_fault`.
- **Unsolicited response:** `m_resp` while `iss_vld`=0 is ignored.
- **Read data:** `i_rdata` and `d_rdata` both equal `m_rdata` combinationally. Only `resp` qualifies them.
- **Writes:** writes are forwarded downstream unchanged. The ROM faults them, the arbiter still returns `resp`, and `fault`=1 in that cycle.

## Timing
- **Reset (async assert):** all registered state clears:
  - busy flags, pending valid, `iss_vld`, `proto_err` = 0
  - round-robin pointer = i-port
- **Output values while reset is asserted:** `i_resp`, `d_resp`, `i_fault`, `d_fault`, `m_req` = 0.
- **Reset mid-operation:** outstanding and pending accesses are discarded and no `resp` is produced for them. A stray `m_resp` in the first cycle after release is ignored.
- **Uncontended access:** `req` at cycle t, `m_req` at t, `resp` at t+1.
- **Lost arbitration or displaced by pending:** issued at t+1, `resp` at t+2. A request never waits more than 1 cycle.
- **Throughput:** sustained one downstream access per cycle.
- **Simultaneous resp and new req on one port:** the resp completes and the new request is accepted in the same cycle.

## Test plan
Bench downstream model: `m_resp` = `m_req` delayed 1 cycle; `m_rdata` = {20'h0, `m_addr`}; `m_fault` = `m_req & m_wr_b`.

- **Solo read:** `i_req` with addr 0x104 at t → `m_req`=1 at t; `i_resp`=1 and `i_rdata`=0x104 at t+1; `d_resp` stays 0.
- **Simultaneous reads after reset:** `i` addr 0x010 and `d` addr 0x020 at t → `i_resp` at t+1 with 0x010, `d_resp` at t+2 with 0x020. Repeat the same pair → `d` wins this time (pointer flipped).
- **Pending beats fresh:** both ports at t, i-port re-requests addr 0x030 at t+1 → `d_resp` at t+2, `i_resp` 0x030 at t+3; `m_req` high at t, t+1, t+2.
- **Write:** `d_req` with `d_wr_b`=1 at t → `d_resp`=1 and `d_fault`=1 at t+1; `i_fault` stays 0.
- **Protocol violation:** `i_req` at t and again at t+1 while busy and not in its resp cycle (hold `m_resp` low at t+1 to force this) → second request dropped, no second `m_req`, `proto_err`=1 and stays 1.
- **Reset mid-operation:** both ports request at t, `rstn` pulled low at t+1 → no `i_resp`/`d_resp` afterwards, `proto_err`=0, pointer back to i-port.
